// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e    : front-end FSM states (idle after reset, fetching, draining stale fetches)
//   NEXT_PC_*        : encodings of the control unit's next_PC_sel steering input
//   NOP              : instruction presented to decode when nothing is buffered
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  localparam logic [1:0] NEXT_PC_SEQ      = 2'b00;
  localparam logic [1:0] NEXT_PC_HOLD     = 2'b01;
  localparam logic [1:0] NEXT_PC_REDIRECT = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering returned instructions toward decode.
// Ports:
//   clock, reset      : clock and synchronous active-low reset
//   push, push_data   : write one entry (ignored when full and not popping)
//   pop               : remove the head entry (ignored when empty)
//   flush             : discard all entries; takes priority over push/pop
//   head_data         : current head entry (undefined when empty)
//   count, full, empty: occupancy status
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned Width = 52,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] head_data,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the PC, issues instruction-memory requests under a credit
// limit, squashes responses made stale by a redirect and buffers good ones toward decode.
// Ports:
//   clock, reset                  : clock and synchronous active-low reset
//   next_PC_sel, target_PC        : PC steering from the control unit (00 seq, 01/11 hold, 10 redirect)
//   i_mem_read                    : control unit permits a fetch this cycle
//   i_req_valid/addr/ready        : instruction-memory request channel
//   i_rsp_valid/data/addr         : in-order instruction-memory responses (always accepted)
//   inst_valid/instruction/inst_PC: head of the instruction buffer (NOP and PC 0 when empty)
//   decode_ready                  : decode consumes the head this cycle
//   scan                          : enables per-cycle state prints
// Build option: define FETCH_SCAN_EN to compile in a cycle counter and scan prints.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned                 CORE            = 0,
  parameter int unsigned                 ADDRESS_BITS    = 20,
  parameter logic [ADDRESS_BITS-1:0]     RESET_PC        = '0,
  parameter int unsigned                 DEPTH           = 2,
  parameter int unsigned                 SCAN_CYCLES_MIN = 0,
  parameter int unsigned                 SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              next_PC_sel,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    i_mem_read,
  output logic                    i_req_valid,
  output logic [ADDRESS_BITS-1:0] i_req_addr,
  input  logic                    i_req_ready,
  input  logic                    i_rsp_valid,
  input  logic [31:0]             i_rsp_data,
  input  logic [ADDRESS_BITS-1:0] i_rsp_addr,
  output logic                    inst_valid,
  output logic [31:0]             instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  input  logic                    decode_ready,
  input  logic                    scan
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned Width = 32 + ADDRESS_BITS;

  typedef logic [CntW-1:0] cnt_t;

  fetch_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  cnt_t                    outstanding_q, outstanding_d;
  cnt_t                    squash_q, squash_d;

  logic             redirect, fire, credit_ok, rsp_drop, rsp_keep, fifo_pop;
  logic [CntW:0]    credit_used;
  cnt_t             fifo_count;
  logic             fifo_full, fifo_empty;
  logic [Width-1:0] fifo_head;

  assign redirect = (next_PC_sel == NEXT_PC_REDIRECT);

  // Credits cover both in-flight requests and buffered instructions, so every response that
  // survives squashing is guaranteed a FIFO slot.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < (CntW + 1)'(DEPTH);

  assign i_req_valid = (state_q != StIdle) & i_mem_read & ~redirect & credit_ok;
  assign i_req_addr  = pc_q;
  assign fire        = i_req_valid & i_req_ready;

  assign rsp_drop = i_rsp_valid & (squash_q != '0);
  // A response landing on a redirect cycle belongs to the old path and is dropped too.
  assign rsp_keep = i_rsp_valid & (squash_q == '0) & ~redirect;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + cnt_t'(fire) - cnt_t'(i_rsp_valid);
    squash_d      = squash_q;

    // Every request still in flight after this cycle predates the redirect.
    if (redirect) begin
      squash_d = outstanding_q - cnt_t'(i_rsp_valid);
    end else if (rsp_drop) begin
      squash_d = squash_q - cnt_t'(1);
    end

    case (next_PC_sel)
      NEXT_PC_REDIRECT: pc_d = target_PC;
      NEXT_PC_SEQ:      if (fire) pc_d = pc_q + ADDRESS_BITS'(4);
      NEXT_PC_HOLD:     pc_d = pc_q;
      default:          pc_d = pc_q;
    endcase

    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (redirect && squash_d != '0) state_d = StDrain;
      StDrain: if (squash_d == '0) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      squash_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
    end
  end

  assign fifo_pop = inst_valid & decode_ready;

  fetch_fifo #(
    .Width (Width),
    .Depth (DEPTH)
  ) u_fetch_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data ({i_rsp_data, i_rsp_addr}),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid  = ~fifo_empty;
  assign instruction = fifo_empty ? NOP : fifo_head[Width-1 -: 32];
  assign inst_PC     = fifo_empty ? '0 : fifo_head[ADDRESS_BITS-1:0];

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
    (rsp_keep && fifo_full) |-> fifo_pop);
  a_no_underflow : assert property (@(posedge clock) disable iff (!reset)
    i_rsp_valid |-> (outstanding_q != '0));

`ifdef FETCH_SCAN_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clock) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (scan && cycle_q >= SCAN_CYCLES_MIN && cycle_q <= SCAN_CYCLES_MAX) begin
      $display("[fetch %0d] cycle=%0d state=%s pc=%h outstanding=%0d squash=%0d fifo=%0d v=%b pc=%h",
               CORE, cycle_q, state_q.name(), pc_q, outstanding_q, squash_q, fifo_count,
               inst_valid, inst_PC);
    end
  end
`else
  logic unused_scan;
  assign unused_scan = ^{scan, CORE[0], SCAN_CYCLES_MIN[0], SCAN_CYCLES_MAX[0]};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned AB    = 20;
  localparam int unsigned DEPTH = 2;
  localparam logic [AB-1:0] RESET_PC = '0;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam int NCYC = 4000;

  logic          clock, reset;
  logic [1:0]    next_PC_sel;
  logic [AB-1:0] target_PC;
  logic          i_mem_read, i_req_valid, i_req_ready;
  logic [AB-1:0] i_req_addr;
  logic          i_rsp_valid;
  logic [31:0]   i_rsp_data;
  logic [AB-1:0] i_rsp_addr;
  logic          inst_valid;
  logic [31:0]   instruction;
  logic [AB-1:0] inst_PC;
  logic          decode_ready, scan;

  fetch_unit #(
    .CORE            (0),
    .ADDRESS_BITS    (AB),
    .RESET_PC        (RESET_PC),
    .DEPTH           (DEPTH),
    .SCAN_CYCLES_MIN (0),
    .SCAN_CYCLES_MAX (1000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .next_PC_sel  (next_PC_sel),
    .target_PC    (target_PC),
    .i_mem_read   (i_mem_read),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_ready  (i_req_ready),
    .i_rsp_valid  (i_rsp_valid),
    .i_rsp_data   (i_rsp_data),
    .i_rsp_addr   (i_rsp_addr),
    .inst_valid   (inst_valid),
    .instruction  (instruction),
    .inst_PC      (inst_PC),
    .decode_ready (decode_ready),
    .scan         (scan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [AB-1:0] addr;
    logic [31:0]   data;
  } inst_t;

  typedef struct {
    logic [AB-1:0] addr;
    int            epoch;
    int            ready_cyc;
  } req_t;

  // Reference model: what decode should see, and what memory still owes.
  inst_t exp_q[$];
  req_t  mem_q[$];
  logic [AB-1:0] m_pc;
  bit            m_idle;
  int            m_epoch;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] data_of(input logic [AB-1:0] a);
    logic [31:0] x;
    x = {12'h0, a};
    return (x * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares the decode-side output against the scoreboard each cycle.
  always begin
    @(negedge clock);
    #2;
    check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instruction", 64'(instruction), 64'(exp_q[0].data));
      check("inst_PC", 64'(inst_PC), 64'(exp_q[0].addr));
      if (decode_ready) void'(exp_q.pop_front());
    end else begin
      check("nop_when_empty", 64'(instruction), 64'(NOP_I));
      check("pc_when_empty", 64'(inst_PC), 64'(0));
    end
  end

  // Driver plus request-side model.
  initial begin
    bit            rst_now, exp_rv, fire;
    int            r;
    req_t          h;
    logic [AB-1:0] tgt;

    reset = 1'b0; next_PC_sel = 2'b00; target_PC = '0; i_mem_read = 1'b0;
    i_req_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_data = '0; i_rsp_addr = '0;
    decode_ready = 1'b0; scan = 1'b0;
    m_pc = RESET_PC; m_idle = 1'b1; m_epoch = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      rst_now = (c < 2) || (c == 1200) || (c == 2600) || (c == 2601);
      reset   = rst_now ? 1'b0 : 1'b1;

      if (c < 14) begin
        // Opening: straight-line fetch with decode stalled to hit the credit limit.
        next_PC_sel  = 2'b00;
        i_mem_read   = 1'b1;
        i_req_ready  = 1'b1;
        decode_ready = (c >= 10);
      end else begin
        r = $urandom_range(0, 99);
        next_PC_sel  = (r < 70) ? 2'b00 : (r < 80) ? 2'b01 : (r < 86) ? 2'b11 : 2'b10;
        i_mem_read   = ($urandom_range(0, 99) < 85);
        i_req_ready  = ($urandom_range(0, 99) < 75);
        decode_ready = ($urandom_range(0, 99) < 60);
      end
      case ($urandom_range(0, 3))
        0:       tgt = 20'h00100;
        1:       tgt = 20'hFFFFC;
        2:       tgt = 20'hFFFF8;
        default: tgt = 20'($urandom) & 20'hFFFFC;
      endcase
      target_PC = tgt;

      i_rsp_valid = 1'b0;
      i_rsp_addr  = 20'($urandom);
      i_rsp_data  = $urandom;
      if (!rst_now && mem_q.size() != 0 && mem_q[0].ready_cyc <= c) begin
        i_rsp_valid = 1'b1;
        i_rsp_addr  = mem_q[0].addr;
        i_rsp_data  = data_of(mem_q[0].addr);
      end

      #1;
      exp_rv = !m_idle && i_mem_read && (next_PC_sel != 2'b10) &&
               (mem_q.size() + exp_q.size() < DEPTH);
      check("i_req_valid", 64'(i_req_valid), 64'(exp_rv));
      if (exp_rv) check("i_req_addr", 64'(i_req_addr), 64'(m_pc));

      #2;
      fire = exp_rv && i_req_ready;
      if (rst_now) begin
        exp_q.delete();
        mem_q.delete();
        m_pc    = RESET_PC;
        m_idle  = 1'b1;
        m_epoch = 0;
      end else begin
        if (i_rsp_valid) begin
          h = mem_q.pop_front();
          if (h.epoch == m_epoch && next_PC_sel != 2'b10)
            exp_q.push_back('{addr: h.addr, data: data_of(h.addr)});
        end
        if (next_PC_sel == 2'b10) begin
          exp_q.delete();
          m_epoch++;
          m_pc = target_PC;
        end else if (fire) begin
          mem_q.push_back('{addr: m_pc, epoch: m_epoch,
                            ready_cyc: c + 1 + int'($urandom_range(0, 3))});
          if (next_PC_sel == 2'b00) m_pc = m_pc + 20'd4;
        end
        m_idle = 1'b0;
      end
    end

    @(negedge clock);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Consumes the control unit's PC-steering outputs (next_PC_sel, target_PC, i_mem_read) and drives the instruction-memory request/response interface.
- Holds the architectural PC and tracks outstanding fetches.
- Squashes stale responses after a redirect.
- Buffers returned instructions in a small FIFO toward decode.

Parameters:
- CORE, 0, core index; used in scan messages.
- ADDRESS_BITS, 20, PC/address width.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, max outstanding requests plus buffered instructions (power of 2, >=2).
- SCAN_CYCLES_MIN, 0, first cycle of the scan print window.
- SCAN_CYCLES_MAX, 1000, last cycle of the scan print window.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low reset
- next_PC_sel  in  2  00 sequential, 01 hold, 10 redirect to target_PC, 11 reserved (treated as hold)
- target_PC  in  ADDRESS_BITS  redirect target
- i_mem_read  in  1  control unit permits a fetch this cycle
- i_req_valid  out  1  request valid
- i_req_addr  out  ADDRESS_BITS  request address (= PC)
- i_req_ready  in  1  memory accepts request
- i_rsp_valid  in  1  response valid; in-order, always accepted
- i_rsp_data  in  32  response instruction
- i_rsp_addr  in  ADDRESS_BITS  address of the response
- inst_valid  out  1  instruction available to decode
- instruction  out  32  head instruction; 32'h00000013 (NOP) when empty
- inst_PC  out  ADDRESS_BITS  PC of the head instruction
- decode_ready  in  1  decode consumes the head this cycle
- scan  in  1  enables scan prints

Behaviour:
- Reset (reset==0 at a clock edge): PC=RESET_PC, outstanding=0, squash=0, FIFO empty, state=IDLE. Outputs: i_req_valid=0, inst_valid=0, instruction=NOP, inst_PC=0.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE lasts exactly one cycle after reset release, with no request; then FETCH.
  - FETCH -> DRAIN on a redirect while inflight>0.
  - DRAIN -> FETCH when squash reaches 0.
  - A redirect in DRAIN reloads squash.
- Issue rule: i_req_valid = (state!=IDLE) & i_mem_read & (next_PC_sel!=10) & (outstanding + fifo_count < DEPTH). Combinational from registers and inputs; no dependence on i_req_ready.
- Fire = i_req_valid & i_req_ready. On fire with next_PC_sel==00: PC += 4, with wrap modulo 2^ADDRESS_BITS. Hold (01/11): PC unchanged, and a request may still be reissued.
- Redirect (10), any state: PC <= target_PC the same cycle; no request issued that cycle.
  - squash <= outstanding minus any non-squashed response arriving that cycle; such a response is dropped.
  - FIFO flushed.
  - Next cycle's request address = target_PC.
- Responses: if squash>0, drop and decrement squash and outstanding. Otherwise push {data, addr} into the FIFO and decrement outstanding.
  - Simultaneous fire and response: outstanding is unchanged.
  - The credit rule guarantees no overflow; a push to a full FIFO is an assertion failure.
- FIFO: first-word latency 1 cycle (response at cycle N gives inst_valid at N+1).
  - Pop on inst_valid & decode_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Pop when empty is ignored.
- Counters are log2(DEPTH)+1 bits. outstanding never exceeds DEPTH; underflow on an unexpected response is an assertion failure.
- Reset mid-operation: all state cleared. Memory must be reset in the same cycle; responses to pre-reset requests are illegal.

Optional Feature:
- Macro FETCH_SCAN_EN.
- Defined: a free-running cycle counter is compiled in. When scan==1 and the counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], each cycle $display prints CORE, cycle, state, PC, outstanding, squash, fifo_count, inst_valid and inst_PC.
- Undefined: no counter and no prints; the scan port is present but unused.

Decomposition:
- Shared package: FSM state encodings, NEXT_PC_SEQ/HOLD/REDIRECT constants, NOP constant 32'h00000013.
- One sub-module, fetch_fifo: parameterised sync FIFO (width 32+ADDRESS_BITS, DEPTH). Interfaces: push/pop/flush, count, full/empty. Active-low synchronous reset.

Test Plan:
- Reset release with i_mem_read=1, sel=00, ready=1 -> no request in cycle 0; requests at 0x0, 0x4 in the next two cycles; third request blocked (DEPTH=2) until a response arrives.
- Responses at 0x0/0x4 with decode_ready=0 -> inst_valid=1, inst_PC=0x0. Issue stalls (outstanding+fifo=2). decode_ready=1 for 2 cycles -> 0x4 presented, then empty and instruction=NOP.
- Redirect sel=10, target_PC=0x100, with 2 outstanding -> FIFO flushed, state DRAIN, squash=2. Both later responses dropped; next request addr=0x100; state returns to FETCH.
- Redirect in the same cycle as a response arrives -> that response dropped; squash=outstanding-1; no inst_valid.
- sel=01 hold for 3 cycles with ready=0 -> i_req_addr stays constant and PC unchanged. PC=0xFFFFC (20-bit) with sequential fire -> PC wraps to 0x00000.
- Reset asserted while in DRAIN with squash=1 -> next cycle state IDLE, squash=0, FIFO empty, PC=RESET_PC.
